imgproc_msg_reader: RTL and testbench



---
 rtl/imgproc_msg_reader_if.sv | 30 +++
 rtl/imgproc_msg_reader.sv | 162 ++++++++++++++++
 tb/tb_imgproc_msg_reader.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imgproc_msg_reader_if.sv
// Avalon-MM master bus plus the decoded-message valid/ready stream of the
// image-processing message reader.
interface imgproc_msg_reader_if;
  logic        m_chipselect;
  logic        m_read;
  logic        m_write;
  logic [2:0]  m_address;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;

  logic        msg_valid;
  logic        msg_ready;
  logic [15:0] msg_distance;
  logic [7:0]  msg_angle;
  logic        msg_detected;

  modport master (
    output m_chipselect, m_read, m_write, m_address, m_writedata,
    input  m_readdata,
    output msg_valid, msg_distance, msg_angle, msg_detected,
    input  msg_ready
  );

  modport slave (
    input  m_chipselect, m_read, m_write, m_address, m_writedata,
    output m_readdata,
    input  msg_valid, msg_distance, msg_angle, msg_detected,
    output msg_ready
  );
endinterface

// File: rtl/imgproc_msg_reader.sv
// Polls the image-processing slave, pops detection messages one word at a time
// and presents each decoded word on a valid/ready stream.
module imgproc_msg_reader #(
  parameter int unsigned POLL_INTERVAL = 1024,
  parameter logic [31:0] EXPECTED_ID   = 32'h1234EEE2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   flush_req,
  imgproc_msg_reader_if.master   io,
  output logic                   id_error,
  output logic [15:0]            msg_count
);

  typedef enum logic [3:0] {
    ID_RD, ID_WT, ERR, IDLE, ST_RD, ST_WT, MSG_RD, MSG_WT, OUT, FLUSH
  } state_t;

  typedef struct packed {
    logic        cs;
    logic        rd;
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
  } bus_t;

  localparam logic [2:0]  ADDR_STATUS = 3'd0;
  localparam logic [2:0]  ADDR_MSG    = 3'd1;
  localparam logic [2:0]  ADDR_ID     = 3'd2;
  localparam logic [31:0] FLUSH_CMD   = 32'h0000_0010;
  localparam int          CW          = $clog2(POLL_INTERVAL);
  localparam logic [CW-1:0] POLL_LAST = CW'(POLL_INTERVAL - 1);

  state_t        state;
  bus_t          bus_q;
  logic [CW-1:0] poll_cnt;
  logic [7:0]    pending;
  logic          flush_pend;
  logic          valid_q;
  logic [15:0]   distance_q;
  logic [7:0]    angle_q;
  logic          detected_q;

  // Bus strobe issued while the FSM sits in a given state.
  function automatic bus_t strobe_for(state_t s);
    bus_t b;
    b = '0;
    case (s)
      ID_RD:  begin b.cs = 1'b1; b.rd = 1'b1; b.addr = ADDR_ID;     end
      ST_RD:  begin b.cs = 1'b1; b.rd = 1'b1; b.addr = ADDR_STATUS; end
      MSG_RD: begin b.cs = 1'b1; b.rd = 1'b1; b.addr = ADDR_MSG;    end
      FLUSH:  begin b.cs = 1'b1; b.wr = 1'b1; b.addr = ADDR_STATUS; b.wdata = FLUSH_CMD; end
      default: ;
    endcase
    return b;
  endfunction

  // Strobes are registered on entry to their state, so the state register
  // always names the bus cycle currently visible on the outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ID_RD;
      bus_q      <= '0;
      poll_cnt   <= '0;
      pending    <= '0;
      flush_pend <= 1'b0;
      valid_q    <= 1'b0;
      distance_q <= '0;
      angle_q    <= '0;
      detected_q <= 1'b0;
      id_error   <= 1'b0;
      msg_count  <= '0;
    end else begin
      // NOTE: non-blocking throughout; a later assignment in the same cycle
      // overrides an earlier default (strobe clear, flush flag merge/clear).
      bus_q <= '0;
      if (flush_req) flush_pend <= 1'b1;

      case (state)
        ID_RD: begin
          // Reset leaves the strobe low, so the first cycle only raises it.
          if (!bus_q.rd) bus_q <= strobe_for(ID_RD);
          else           state <= ID_WT;
        end
        ID_WT: begin
          if (io.m_readdata == EXPECTED_ID) begin
            state    <= IDLE;
            poll_cnt <= '0;
          end else begin
            id_error <= 1'b1;
            state    <= ERR;
          end
        end
        ERR: ;
        IDLE: begin
          if (enable && flush_pend) begin
            state <= FLUSH;
            bus_q <= strobe_for(FLUSH);
          end else if (poll_cnt == POLL_LAST) begin
            if (enable) begin
              state <= ST_RD;
              bus_q <= strobe_for(ST_RD);
            end
          end else begin
            poll_cnt <= poll_cnt + CW'(1);
          end
        end
        ST_RD: state <= ST_WT;
        ST_WT: begin
          pending <= io.m_readdata[15:8];
          if (io.m_readdata[15:8] != 8'd0 && enable) begin
            state <= MSG_RD;
            bus_q <= strobe_for(MSG_RD);
          end else begin
            state    <= IDLE;
            poll_cnt <= '0;
          end
        end
        MSG_RD: state <= MSG_WT;
        MSG_WT: begin
          distance_q <= io.m_readdata[31:16];
          angle_q    <= io.m_readdata[15:8];
          detected_q <= io.m_readdata[0];
          valid_q    <= 1'b1;
          pending    <= pending - 8'd1;
          state      <= OUT;
        end
        OUT: begin
          if (io.msg_ready) begin
            valid_q   <= 1'b0;
            msg_count <= msg_count + 16'd1;
            if (pending != 8'd0 && enable) begin
              state <= MSG_RD;
              bus_q <= strobe_for(MSG_RD);
            end else begin
              state    <= IDLE;
              poll_cnt <= '0;
            end
          end
        end
        FLUSH: begin
          flush_pend <= flush_req;
          state      <= IDLE;
          poll_cnt   <= '0;
        end
        default: state <= ID_RD;
      endcase
    end
  end

  assign io.m_chipselect = bus_q.cs;
  assign io.m_read       = bus_q.rd;
  assign io.m_write      = bus_q.wr;
  assign io.m_address    = bus_q.addr;
  assign io.m_writedata  = bus_q.wdata;
  assign io.msg_valid    = valid_q;
  assign io.msg_distance = distance_q;
  assign io.msg_angle    = angle_q;
  assign io.msg_detected = detected_q;

endmodule

// File: tb/tb_imgproc_msg_reader.sv
// Scoreboard bench for imgproc_msg_reader: a slave model with a message FIFO,
// a bus/stream monitor, and directed scenarios with hand-computed messages.
module tb_imgproc_msg_reader;
  localparam int unsigned POLL    = 8;
  localparam logic [31:0] GOOD_ID = 32'h1234EEE2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        flush_req = 1'b0;
  logic        id_error;
  logic [15:0] msg_count;

  imgproc_msg_reader_if bus ();

  imgproc_msg_reader #(.POLL_INTERVAL(POLL), .EXPECTED_ID(GOOD_ID)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .flush_req (flush_req),
    .io        (bus.master),
    .id_error  (id_error),
    .msg_count (msg_count)
  );

  always #5 clk = ~clk;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int cyc        = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Slave model: fixed read latency 1, message FIFO popped per read strobe.
  logic [31:0] slave_id = GOOD_ID;
  logic [31:0] fifo[$];

  always @(posedge clk) begin
    if (bus.m_chipselect && bus.m_read) begin
      case (bus.m_address)
        3'd0: bus.m_readdata <= {16'h0, 8'(fifo.size()), 8'h00};
        3'd1: begin
          if (fifo.size() != 0) bus.m_readdata <= fifo.pop_front();
          else                  bus.m_readdata <= 32'h0;
        end
        3'd2:    bus.m_readdata <= slave_id;
        default: bus.m_readdata <= 32'h0;
      endcase
    end else begin
      bus.m_readdata <= 32'hBAD0_BAD0;
    end
    if (bus.m_chipselect && bus.m_write && bus.m_address == 3'd0 && bus.m_writedata[4])
      fifo.delete();
  end

  // Monitor state shared with the stimulus process.
  logic [24:0] sb[$];
  logic [24:0] cur, held, exp_msg;
  bit          prev_read, held_valid;
  int          strobe_cnt = 0, st_cnt = 0, msg_rd_cnt = 0, wr_cnt = 0;
  int          last_st_cyc = 0, prev_st_cyc = 0, last_id_cyc = 0, last_msg_rd_cyc = 0;
  int          msg_rd_cyc[$];

  initial forever begin
    @(negedge clk);
    if (reset) begin
      prev_read  = 1'b0;
      held_valid = 1'b0;
    end else begin
      cur = {bus.msg_distance, bus.msg_angle, bus.msg_detected};
      if (bus.m_read || bus.m_write) begin
        strobe_cnt++;
        check("cs_with_strobe", 64'(bus.m_chipselect), 64'(1));
      end else begin
        check("idle_bus", 64'({bus.m_chipselect, bus.m_address, bus.m_writedata}), 64'(0));
      end
      if (bus.m_read) begin
        check("read_not_back_to_back", 64'(prev_read), 64'(0));
        case (bus.m_address)
          3'd0: begin st_cnt++; prev_st_cyc = last_st_cyc; last_st_cyc = cyc; end
          3'd1: begin
            msg_rd_cnt++;
            last_msg_rd_cyc = cyc;
            msg_rd_cyc.push_back(cyc);
            check("no_msg_read_while_valid", 64'(bus.msg_valid), 64'(0));
          end
          3'd2: last_id_cyc = cyc;
          default: ;
        endcase
      end
      if (bus.m_write) begin
        wr_cnt++;
        check("flush_write", 64'({bus.m_address, bus.m_writedata}), 64'({3'd0, 32'h10}));
      end
      prev_read = bus.m_read;
      if (bus.msg_valid) begin
        if (held_valid) check("fields_stable", 64'(cur), 64'(held));
        else            check("msg_latency", 64'(cyc - last_msg_rd_cyc), 64'(2));
        held = cur;
        if (bus.msg_ready) begin
          if (sb.size() != 0) begin
            exp_msg = sb.pop_front();
            check("msg_fields", 64'(cur), 64'(exp_msg));
          end else begin
            assert_cnt++;
            fail_cnt++;
            $display("FAIL msg_unexpected: actual 0x%0h required no message", cur);
          end
          held_valid = 1'b0;
        end else begin
          held_valid = 1'b1;
        end
      end else begin
        held_valid = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w, input bit expect_msg,
                           input logic [15:0] d, input logic [7:0] a, input logic det);
    fifo.push_back(w);
    if (expect_msg) sb.push_back({d, a, det});
  endtask

  int base, base_wr;

  initial begin
    bus.msg_ready = 1'b0;
    enable        = 1'b1;
    reset         = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_bus", 64'({bus.m_chipselect, bus.m_read, bus.m_write, bus.m_address, bus.m_writedata}), 64'(0));
    check("reset_msg", 64'({bus.msg_valid, bus.msg_distance, bus.msg_angle, bus.msg_detected}), 64'(0));
    check("reset_status", 64'({id_error, msg_count}), 64'(0));
    step();
    reset = 1'b0;

    // ID accepted, then periodic status polling.
    for (int i = 0; i < 200 && st_cnt < 2; i++) @(negedge clk);
    check("poll_started", 64'(st_cnt >= 2), 64'(1));
    check("id_to_first_poll", 64'(prev_st_cyc - last_id_cyc), 64'(POLL + 2));
    check("poll_period", 64'(last_st_cyc - prev_st_cyc), 64'(POLL + 2));
    check("id_error_clear", 64'(id_error), 64'(0));

    // Drain two messages with the consumer always ready.
    step();
    bus.msg_ready = 1'b1;
    msg_rd_cyc.delete();
    base = msg_rd_cnt;
    push_word(32'h01F4_E6_01, 1'b1, 16'd500, 8'hE6, 1'b1);
    push_word(32'h0320_1E_00, 1'b1, 16'd800, 8'h1E, 1'b0);
    for (int i = 0; i < 100 && msg_count != 16'd2; i++) @(negedge clk);
    check("drain_count", 64'(msg_count), 64'(2));
    check("drain_rd_num", 64'(msg_rd_cyc.size()), 64'(2));
    if (msg_rd_cyc.size() >= 2) begin
      check("msg_rd_spacing", 64'(msg_rd_cyc[1] - msg_rd_cyc[0]), 64'(3));
      check("status_to_msg_rd", 64'(msg_rd_cyc[0] - last_st_cyc), 64'(2));
    end
    repeat (POLL + 4) @(negedge clk);
    check("drain_back_idle", 64'(msg_rd_cnt - base), 64'(2));

    // Backpressure with three pending words.
    step();
    bus.msg_ready = 1'b0;
    push_word(32'h0064_0A_01, 1'b1, 16'd100, 8'h0A, 1'b1);
    push_word(32'h00C8_F6_01, 1'b1, 16'd200, 8'hF6, 1'b1);
    push_word(32'h012C_00_00, 1'b1, 16'd300, 8'h00, 1'b0);
    for (int i = 0; i < 100 && !bus.msg_valid; i++) @(negedge clk);
    check("bp_valid_seen", 64'(bus.msg_valid), 64'(1));
    base = msg_rd_cnt;
    repeat (50) @(negedge clk);
    check("bp_no_msg_read", 64'(msg_rd_cnt - base), 64'(0));
    check("bp_still_held", 64'(bus.msg_valid), 64'(1));
    step();
    bus.msg_ready = 1'b1;
    for (int i = 0; i < 100 && msg_count != 16'd5; i++) @(negedge clk);
    check("bp_count", 64'(msg_count), 64'(5));

    // Flush requested twice while a message is held.
    step();
    bus.msg_ready = 1'b0;
    base_wr = wr_cnt;
    push_word(32'h07D0_5A_01, 1'b1, 16'd2000, 8'h5A, 1'b1);
    push_word(32'h0001_80_00, 1'b1, 16'd1,    8'h80, 1'b0);
    for (int i = 0; i < 100 && !bus.msg_valid; i++) @(negedge clk);
    check("flush_valid_seen", 64'(bus.msg_valid), 64'(1));
    step(); flush_req = 1'b1;
    step(); flush_req = 1'b0;
    step(); flush_req = 1'b1;
    step(); flush_req = 1'b0;
    repeat (5) @(negedge clk);
    check("no_write_during_out", 64'(wr_cnt - base_wr), 64'(0));
    step();
    bus.msg_ready = 1'b1;
    for (int i = 0; i < 100 && msg_count != 16'd7; i++) @(negedge clk);
    check("flush_msgs_count", 64'(msg_count), 64'(7));
    repeat (20) @(negedge clk);
    check("one_flush_write", 64'(wr_cnt - base_wr), 64'(1));

    // enable low stops polling; raising it resumes.
    step();
    enable = 1'b0;
    repeat (20) @(negedge clk);
    base = st_cnt;
    repeat (40) @(negedge clk);
    check("disable_stops_poll", 64'(st_cnt - base), 64'(0));
    step();
    enable = 1'b1;
    for (int i = 0; i < 30 && st_cnt == base; i++) @(negedge clk);
    check("enable_resumes_poll", 64'(st_cnt != base), 64'(1));

    // Reset while the popped word is being sampled.
    step();
    push_word(32'hABCD_12_01, 1'b0, 16'd0, 8'd0, 1'b0);
    for (int i = 0; i < 100 && !(bus.m_read && bus.m_address == 3'd1); i++) @(negedge clk);
    check("mid_msg_read_seen", 64'(bus.m_read && bus.m_address == 3'd1), 64'(1));
    step();
    reset = 1'b1;
    #1;
    check("async_reset_bus", 64'({bus.m_chipselect, bus.m_read, bus.m_write, bus.m_address, bus.m_writedata}), 64'(0));
    check("async_reset_msg", 64'({bus.msg_valid, bus.msg_distance, bus.msg_angle, bus.msg_detected}), 64'(0));
    check("async_reset_status", 64'({id_error, msg_count}), 64'(0));
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 10 && !bus.m_read; i++) @(negedge clk);
    check("id_read_reissued", 64'({bus.m_read, bus.m_address}), 64'({1'b1, 3'd2}));
    repeat (30) @(negedge clk);
    check("lost_word_not_delivered", 64'(msg_count), 64'(0));

    // Wrong ID: sticky error and a silent bus.
    step();
    slave_id = 32'hDEADBEEF;
    reset    = 1'b1;
    step();
    reset    = 1'b0;
    repeat (10) @(negedge clk);
    check("id_error_set", 64'(id_error), 64'(1));
    base = strobe_cnt;
    repeat (1000) @(negedge clk);
    check("err_no_strobes", 64'(strobe_cnt - base), 64'(0));
    check("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end
endmodule
